// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and helpers for the byte-serial data-memory master.
//   - state_t        : transfer FSM states
//   - op_t           : latched access direction
//   - BYTES_PER_WORD : beats per 32-bit word
//   - BEAT_W         : width of the beat counter
//   - byte_lane()    : big-endian byte of a word for a given beat
//                      (beat 0 -> bits [31:24], beat 3 -> bits [7:0])
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Big-endian lane select: shifting left by 8*beat brings the wanted byte
  // to the top, which avoids a variable part-select.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [BEAT_W-1:0] beat);
    logic [31:0] w_shifted;
    w_shifted = word << {beat, 3'b000};
    return w_shifted[31:24];
  endfunction

endpackage

// File: rtl/dmem_byte_master.sv
// -----------------------------------------------------------------------------
// dmem_byte_master
//   CPU-side initiator for the byte-organised data memory. One 32-bit load or
//   store from the MEM stage is executed as four serial byte beats on an
//   8-bit memory port, big-endian (byte at the start address is bits [31:24]).
//   The pipeline is stalled from the request cycle until the transfer ends;
//   done_o pulses for one cycle when the access completes.
//
// Ports
//   clk_i         in   1       clock, rising edge
//   rst_i         in   1       asynchronous reset, active-low
//   MemRead_i     in   1       load request (level)
//   MemWrite_i    in   1       store request (level); wins over MemRead_i
//   addr_i        in   ADDR_W  word start byte address
//   write_data_i  in   32      store data
//   data_o        out  32      last completed load word
//   stall_o       out  1       hold pipeline
//   done_o        out  1       one-cycle completion pulse
//   mem_addr_o    out  ADDR_W  byte address to memory
//   mem_re_o      out  1       byte read strobe
//   mem_we_o      out  1       byte write strobe
//   mem_wdata_o   out  8       byte write data
//   mem_rdata_i   in   8       byte read data, combinational from mem_addr_o
// -----------------------------------------------------------------------------
module dmem_byte_master
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int N_BYTES = 4    // fixed at 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  state_t            r_state;
  state_t            w_next_state;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd_buf;
  logic [31:0]       r_data;
  op_t               r_op;

  logic              w_req;
  logic              w_last_beat;
  logic [31:0]       w_rd_next;

  assign w_req       = MemRead_i | MemWrite_i;
  assign w_last_beat = (r_beat == BEAT_W'(N_BYTES - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req)       w_next_state = ST_XFER;
      ST_XFER: if (w_last_beat) w_next_state = ST_DONE;
      // DONE always returns to IDLE: the request is still high only because
      // the pipeline was held, so it must not start a second access.
      ST_DONE:                  w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes, address and write data exist only in XFER
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o     = 1'b0;
    done_o      = 1'b0;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    unique case (r_state)
      // Stall in the request cycle itself; gated by reset so every output is
      // low while reset is asserted, even with a request pending.
      ST_IDLE: stall_o = w_req & rst_i;
      ST_XFER: begin
        stall_o    = 1'b1;
        // Natural modulo-2^ADDR_W wrap past the top of the address space.
        mem_addr_o = r_addr + ADDR_W'(r_beat);
        if (r_op == OP_WRITE) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = byte_lane(r_wdata, r_beat);
        end else begin
          mem_re_o    = 1'b1;
        end
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Read buffer with the current beat's byte inserted in its big-endian lane.
  always_comb begin
    w_rd_next = r_rd_buf;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      w_rd_next[31-8*i -: 8] = (r_beat == BEAT_W'(i)) ? mem_rdata_i
                                                     : byte_lane(r_rd_buf, BEAT_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values. Every register here is small, so
  // all are reset, which also guarantees data_o reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_beat   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_buf <= '0;
      r_data   <= '0;
      r_op     <= OP_READ;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= addr_i;
            r_wdata <= write_data_i;
            r_op    <= MemWrite_i ? OP_WRITE : OP_READ;
            r_beat  <= '0;
          end
        end
        ST_XFER: begin
          r_beat <= r_beat + BEAT_W'(1);
          if (r_op == OP_READ) begin
            r_rd_buf <= w_rd_next;
            // Publish the word including the final byte on DONE entry, so
            // data_o is already valid while done_o is high.
            if (w_last_beat) r_data <= w_rd_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o = r_data;

endmodule

// File: tb/tb_dmem_byte_master.sv
// -----------------------------------------------------------------------------
// tb_dmem_byte_master
//   Directed bench for dmem_byte_master with a 256-byte reference memory
//   (indexed by the low address byte). Covers reset, store, load, data_o
//   hold across a store, address wrap, simultaneous read/write request,
//   reset in the middle of a store and a request held across two accesses.
// -----------------------------------------------------------------------------
module tb_dmem_byte_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        stall;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_byte_master #(.ADDR_W(32), .N_BYTES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .MemRead_i    (mem_read),
    .MemWrite_i   (mem_write),
    .addr_i       (addr),
    .write_data_i (wdata),
    .data_o       (data),
    .stall_o      (stall),
    .done_o       (done),
    .mem_addr_o   (mem_addr),
    .mem_re_o     (mem_re),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // Reference memory: written at the rising edge, read combinationally.
  logic [7:0] mem [0:255] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Per-cycle record of one access: bit c / entry c is cycle c after request.
  logic [5:0]  s_stall, s_done, s_re, s_we;
  logic [31:0] s_addr [6];
  logic [7:0]  s_wd   [6];
  logic [31:0] s_data;

  // Raise the request just after a rising edge (cycle 0), sample each cycle
  // at the falling edge, drop the request in cycle 5. Ends 1 time unit after
  // the edge that returns the FSM to IDLE.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    for (int c = 0; c < 6; c++) begin
      #4;
      s_stall[c] = stall; s_done[c] = done;
      s_re[c]    = mem_re; s_we[c]  = mem_we;
      s_addr[c]  = mem_addr; s_wd[c] = mem_wdata;
      if (c == 5) begin
        s_data = data;
        mem_read = 1'b0; mem_write = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  int          done_cnt, re_cnt;
  logic [31:0] addr_c1, addr_c7, first_data;
  logic        seen_done;

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;

    // ---- reset state
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_data",  data,       32'h0);
    check("rst_addr",  mem_addr,   32'h0);
    check("rst_strb",  {30'd0, mem_re, mem_we}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // ---- store 0xA1B2C3D4 at 0x10
    access(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4);
    check("st_stall", 32'(s_stall), 32'h1F);
    check("st_done",  32'(s_done),  32'h20);
    check("st_we",    32'(s_we),    32'h1E);
    check("st_re",    32'(s_re),    32'h00);
    check("st_addr0", s_addr[1], 32'h10);
    check("st_addr3", s_addr[4], 32'h13);
    check("st_lane0", 32'(s_wd[1]), 32'hA1);
    check("st_idle_wd", 32'(s_wd[5]), 32'h00);
    check("st_mem",   mem_word(8'h10), 32'hA1B2C3D4);

    // ---- load 11,22,33,44 from 0x10
    access(1'b0, 1'b1, 32'h10, 32'h11223344);
    check("ld_pre_mem", mem_word(8'h10), 32'h11223344);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check("ld_re",    32'(s_re),    32'h1E);
    check("ld_we",    32'(s_we),    32'h00);
    check("ld_stall", 32'(s_stall), 32'h1F);
    check("ld_done",  32'(s_done),  32'h20);
    check("ld_data",  s_data, 32'h11223344);

    // ---- data_o holds through a following store
    access(1'b0, 1'b1, 32'h60, 32'hCAFEF00D);
    check("hold_done_data", s_data, 32'h11223344);
    check("hold_data", data, 32'h11223344);
    check("hold_mem",  mem_word(8'h60), 32'hCAFEF00D);

    // ---- wrap at top of address space (store then load)
    access(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h5A6B7C8D);
    access(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0);
    check("wrap_a0", s_addr[1], 32'hFFFF_FFFE);
    check("wrap_a1", s_addr[2], 32'hFFFF_FFFF);
    check("wrap_a2", s_addr[3], 32'h0000_0000);
    check("wrap_a3", s_addr[4], 32'h0000_0001);
    check("wrap_data", s_data, 32'h5A6B7C8D);

    // ---- both requests high: write wins, data_o unchanged
    access(1'b1, 1'b1, 32'h50, 32'hDEADBEEF);
    check("both_re",   32'(s_re), 32'h00);
    check("both_we",   32'(s_we), 32'h1E);
    check("both_mem",  mem_word(8'h50), 32'hDEADBEEF);
    check("both_data", s_data, 32'h5A6B7C8D);

    // ---- reset after beat 1 of a store
    access(1'b0, 1'b1, 32'h20, 32'hEEEEEEEE);
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h55667788;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_stall", 32'(stall), 32'd0);
    check("mrst_strb",  {30'd0, mem_re, mem_we}, 32'd0);
    check("mrst_addr",  mem_addr, 32'h0);
    check("mrst_wd",    32'(mem_wdata), 32'h0);
    check("mrst_data",  data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mrst_mem", mem_word(8'h20), 32'h5566EEEE);
    mem_write = 1'b0;
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h20, 32'h0);
    check("mrst_next_a0", s_addr[1], 32'h20);
    check("mrst_next_data", s_data, 32'h5566EEEE);

    // ---- request held 12 cycles, address changed during XFER
    access(1'b0, 1'b1, 32'h30, 32'h01020304);
    access(1'b0, 1'b1, 32'h40, 32'h0A0B0C0D);
    done_cnt = 0; re_cnt = 0; seen_done = 1'b0;
    addr_c1 = '0; addr_c7 = '0; first_data = '0;
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h30;
    for (int c = 0; c < 14; c++) begin
      #4;
      done_cnt += int'(done);
      re_cnt   += int'(mem_re);
      if (c == 1) addr_c1 = mem_addr;
      if (c == 7) addr_c7 = mem_addr;
      if (done && !seen_done) begin
        first_data = data;
        seen_done  = 1'b1;
      end
      if (c == 2)  addr = 32'h40;
      if (c == 11) mem_read = 1'b0;
      @(posedge clk); #1;
    end
    check("held_done_cnt", 32'(done_cnt), 32'd2);
    check("held_re_cnt",   32'(re_cnt),   32'd8);
    check("held_addr1",    addr_c1, 32'h30);
    check("held_addr2",    addr_c7, 32'h40);
    check("held_data1",    first_data, 32'h01020304);
    check("held_data2",    data, 32'h0A0B0C0D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
